// File: rtl/panda_risc_v_divider_pkg.sv
// Shared constants for the divider: FSM state encodings and iteration count.
package panda_risc_v_divider_pkg;

    typedef enum logic [1:0] {
        DIV_STS_IDLE = 2'd0,
        DIV_STS_CALC = 2'd1,
        DIV_STS_OUT  = 2'd2
    } div_sts_e;

    localparam int DIV_ITER_N = 32;

endpackage

// File: rtl/panda_risc_v_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, trial-subtract the divisor.
module panda_risc_v_div_step (
    input  logic [32:0] r_i,
    input  logic [31:0] q_i,
    input  logic [31:0] b_i,
    output logic [32:0] r_o,
    output logic [31:0] q_o,
    output logic        q_bit_o
);

    logic [32:0] shl;
    logic [32:0] t;
    logic        unused_r_msb;

    // R stays below the divisor, so its top bit is always zero and is not shifted in
    assign unused_r_msb = r_i[32];
    assign shl          = {r_i[31:0], q_i[31]};
    assign t            = shl - {1'b0, b_i};
    assign q_bit_o      = ~t[32];
    assign r_o          = q_bit_o ? t : shl;
    assign q_o          = {q_i[30:0], q_bit_o};

endmodule

// File: rtl/panda_risc_v_divider.sv
// Iterative DIV/DIVU/REM/REMU unit: sign-magnitude restoring division, one operation in flight.
module panda_risc_v_divider
    import panda_risc_v_divider_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [32:0] s_div_op_a,
    input  logic [32:0] s_div_op_b,
    input  logic        s_div_rem_sel,
    input  logic [4:0]  s_div_rd_id,
    input  logic        s_div_valid,
    output logic        s_div_ready,
    output logic [31:0] m_div_res,
    output logic [4:0]  m_div_res_rd_id,
    output logic        m_div_res_valid,
    input  logic        m_div_res_ready
);

    div_sts_e    state_q;
    logic [5:0]  cnt_q;
    logic [32:0] r_q;
    logic [31:0] q_q;
    logic [31:0] b_q;
    logic        sign_a_q;
    logic        neg_q_q;
    logic        rem_sel_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic        valid_q;
    logic        ready_q;

    logic [32:0] r_d;
    logic [31:0] q_d;
    logic        q_bit_unused;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign mag_a   = s_div_op_a[32] ? (~s_div_op_a[31:0] + 32'd1) : s_div_op_a[31:0];
    assign mag_b   = s_div_op_b[32] ? (~s_div_op_b[31:0] + 32'd1) : s_div_op_b[31:0];
    assign quo_fix = neg_q_q  ? (~q_d + 32'd1)       : q_d;
    assign rem_fix = sign_a_q ? (~r_d[31:0] + 32'd1) : r_d[31:0];

    panda_risc_v_div_step u_step (
        .r_i     (r_q),
        .q_i     (q_q),
        .b_i     (b_q),
        .r_o     (r_d),
        .q_o     (q_d),
        .q_bit_o (q_bit_unused)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_STS_IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            b_q       <= '0;
            sign_a_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            rd_q      <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                DIV_STS_IDLE: begin
                    if (s_div_valid) begin
                        sign_a_q  <= s_div_op_a[32];
                        neg_q_q   <= s_div_op_a[32] ^ s_div_op_b[32];
                        rem_sel_q <= s_div_rem_sel;
                        rd_q      <= s_div_rd_id;
                        b_q       <= mag_b;
                        ready_q   <= 1'b0;
                        if (s_div_op_b == 33'd0) begin
                            // Divide by zero: architectural result, no iterations
                            state_q <= DIV_STS_OUT;
                            res_q   <= s_div_rem_sel ? s_div_op_a[31:0] : 32'hFFFF_FFFF;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= DIV_STS_CALC;
                            cnt_q   <= '0;
                            r_q     <= '0;
                            q_q     <= mag_a;
                        end
                    end
                end
                DIV_STS_CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_ITER_N - 1)) begin
                        state_q <= DIV_STS_OUT;
                        res_q   <= rem_sel_q ? rem_fix : quo_fix;
                        valid_q <= 1'b1;
                    end
                end
                DIV_STS_OUT: begin
                    if (m_div_res_ready) begin
                        state_q <= DIV_STS_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= DIV_STS_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_div_ready     = ready_q;
    assign m_div_res       = res_q;
    assign m_div_res_rd_id = rd_q;
    assign m_div_res_valid = valid_q;

endmodule

// File: tb/tb_panda_risc_v_divider.sv
// Randomized self-checking bench for panda_risc_v_divider against a plain-arithmetic model.
module tb_panda_risc_v_divider;

    logic        clk;
    logic        resetn;
    logic [32:0] s_div_op_a;
    logic [32:0] s_div_op_b;
    logic        s_div_rem_sel;
    logic [4:0]  s_div_rd_id;
    logic        s_div_valid;
    logic        s_div_ready;
    logic [31:0] m_div_res;
    logic [4:0]  m_div_res_rd_id;
    logic        m_div_res_valid;
    logic        m_div_res_ready;

    int n_chk  = 0;
    int n_fail = 0;

    panda_risc_v_divider dut (
        .clk             (clk),
        .resetn          (resetn),
        .s_div_op_a      (s_div_op_a),
        .s_div_op_b      (s_div_op_b),
        .s_div_rem_sel   (s_div_rem_sel),
        .s_div_rd_id     (s_div_rd_id),
        .s_div_valid     (s_div_valid),
        .s_div_ready     (s_div_ready),
        .m_div_res       (m_div_res),
        .m_div_res_rd_id (m_div_res_rd_id),
        .m_div_res_valid (m_div_res_valid),
        .m_div_res_ready (m_div_res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // RISC-V semantics from signed 33-bit arithmetic (truncating division)
    function automatic logic [31:0] ref_div(input logic [32:0] a, input logic [32:0] b, input logic rem);
        longint sa, sb, r;
        if (b == 33'd0) return rem ? a[31:0] : 32'hFFFF_FFFF;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = rem ? (sa % sb) : (sa / sb);
        return r[31:0];
    endfunction

    task automatic send(input logic [32:0] a, input logic [32:0] b, input logic rem, input logic [4:0] rd);
        int w;
        @(negedge clk);
        s_div_op_a    = a;
        s_div_op_b    = b;
        s_div_rem_sel = rem;
        s_div_rd_id   = rd;
        s_div_valid   = 1'b1;
        w = 0;
        while (!s_div_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("req_accept_timeout", 64'(w), 64'd0);
        @(posedge clk);
        #1 s_div_valid = 1'b0;
    endtask

    // Called just after the handshake edge; lat counts cycles from the handshake
    task automatic wait_res(output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = !s_div_ready;
        while (!m_div_res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            if (s_div_ready) busy_ok = 1'b0;
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic [32:0] a, input logic [32:0] b,
                             input logic rem, input logic [4:0] rd);
        int   lat;
        logic busy_ok;
        wait_res(lat, busy_ok);
        chk({tag, "_lat"}, 64'(lat), (b == 33'd0) ? 64'd1 : 64'd33);
        chk({tag, "_res"}, 64'(m_div_res), 64'(ref_div(a, b, rem)));
        chk({tag, "_rd"}, 64'(m_div_res_rd_id), 64'(rd));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic retire(input string tag, input int hold);
        logic [31:0] r0;
        logic [4:0]  d0;
        r0 = m_div_res;
        d0 = m_div_res_rd_id;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_res"}, 64'(m_div_res), 64'(r0));
            chk({tag, "_hold_rd"}, 64'(m_div_res_rd_id), 64'(d0));
        end
        m_div_res_ready = 1'b1;
        @(posedge clk);
        #1 m_div_res_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(m_div_res_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(s_div_ready), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [32:0] a, input logic [32:0] b,
                         input logic rem, input logic [4:0] rd, input int hold);
        send(a, b, rem, rd);
        check_res(tag, a, b, rem, rd);
        retire(tag, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(m_div_res_valid), 64'd0);
        chk({tag, "_ready"}, 64'(s_div_ready), 64'd1);
        chk({tag, "_res"}, 64'(m_div_res), 64'd0);
        chk({tag, "_rd"}, 64'(m_div_res_rd_id), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] a, b;
        logic [31:0] ra, rb;
        int          kind;

        resetn          = 1'b0;
        s_div_op_a      = '0;
        s_div_op_b      = '0;
        s_div_rem_sel   = 1'b0;
        s_div_rd_id     = '0;
        s_div_valid     = 1'b0;
        m_div_res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) resetn = 1'b1;

        do_op("divu_100_7", 33'd100, 33'd7, 1'b0, 5'd5, 0);
        do_op("remu_100_7", 33'd100, 33'd7, 1'b1, 5'd6, 1);
        do_op("div_m7_2",   33'h1_FFFF_FFF9, 33'd2, 1'b0, 5'd7, 0);
        do_op("rem_m7_2",   33'h1_FFFF_FFF9, 33'd2, 1'b1, 5'd8, 0);
        do_op("div0_quo",   33'd1234, 33'd0, 1'b0, 5'd9, 0);
        do_op("div0_rem",   33'd1234, 33'd0, 1'b1, 5'd10, 2);
        do_op("ovf_quo",    33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b0, 5'd11, 0);
        do_op("ovf_rem",    33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b1, 5'd12, 0);

        // Backpressure with a competing request held on the input
        send(33'h0_FFFF_FFFF, 33'd1, 1'b0, 5'd13);
        check_res("bp", 33'h0_FFFF_FFFF, 33'd1, 1'b0, 5'd13);
        s_div_op_a    = 33'd9;
        s_div_op_b    = 33'd3;
        s_div_rem_sel = 1'b0;
        s_div_rd_id   = 5'd14;
        s_div_valid   = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_hold_res", 64'(m_div_res), 64'h0000_0000_FFFF_FFFF);
            chk("bp_hold_rdy", 64'(s_div_ready), 64'd0);
        end
        m_div_res_ready = 1'b1;
        @(posedge clk);
        #1 m_div_res_ready = 1'b0;
        chk("bp_ready_back", 64'(s_div_ready), 64'd1);
        @(posedge clk);
        #1 s_div_valid = 1'b0;
        check_res("bp_next", 33'd9, 33'd3, 1'b0, 5'd14);
        retire("bp_next", 0);

        // Reset in the middle of CALC
        send(33'd1000, 33'd3, 1'b0, 5'd20);
        repeat (14) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("rst_calc");
        @(negedge clk) resetn = 1'b1;
        do_op("after_rst", 33'd9, 33'd3, 1'b0, 5'd17, 0);

        // Reset while a result is waiting
        send(33'd55, 33'd0, 1'b1, 5'd21);
        #1;
        chk("rst_out_pre", 64'(m_div_res_valid), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("rst_out");
        @(negedge clk) resetn = 1'b1;

        for (int i = 0; i < 24; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            kind = $urandom_range(0, 5);
            case (kind)
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                a = {ra[31], ra};
                b = {rb[31], rb};
            end else begin
                a = {1'b0, ra};
                b = {1'b0, rb};
            end
            do_op("rand", a, b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
